// File: rtl/yurut_birim_zamanlayici.sv
// Execute-stage unit sequencer: retires single-cycle ops immediately, starts
// multi-cycle units, stalls decode while they run and reports the result owner.
module yurut_birim_zamanlayici #(
    parameter int unsigned ZAMAN_ASIMI = 64
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       gecerli_i,
    input  logic [2:0] birim_i,
    input  logic       yz_en_i,
    input  logic       bosalt_i,
    input  logic [3:0] bitti_i,
    output logic [3:0] baslat_o,
    output logic       iptal_o,
    output logic       durdur_o,
    output logic       mesgul_o,
    output logic       sonuc_gecerli_o,
    output logic [2:0] sonuc_birim_o,
    output logic       zaman_asimi_o
);
    // state | meaning
    // BOSTA | idle; single-cycle ops retire here, multi-cycle ops get started
    // BEKLE | multi-cycle unit running; decode stalled, watchdog counting
    // TAMAM | one-cycle exit; stall released so the held instruction leaves
    localparam int unsigned SW = $clog2(ZAMAN_ASIMI + 1);
    localparam logic [SW-1:0] SON_SAYI = SW'(ZAMAN_ASIMI - 1);

    typedef enum logic [1:0] {
        BOSTA = 2'd0,
        BEKLE = 2'd1,
        TAMAM = 2'd2
    } durum_t;

    durum_t        durum;
    logic [SW-1:0] sayac;
    logic [2:0]    aktif_birim;
    logic          zaman_doldu;

    logic cok_cevrim;
    logic tek_cevrim;
    logic kabul;
    logic aktif_bitti;

    // Unit code to start/done bit position; codes outside 1..4 map to nothing.
    function automatic logic [3:0] birim_maskesi(input logic [2:0] kod);
        case (kod)
            3'd1:    return 4'b0001;
            3'd2:    return 4'b0010;
            3'd3:    return 4'b0100;
            3'd4:    return 4'b1000;
            default: return 4'b0000;
        endcase
    endfunction

    // The AI unit is only treated as multi-cycle when it is enabled.
    assign cok_cevrim  = (birim_i == 3'd1) || (birim_i == 3'd2) || (birim_i == 3'd3) ||
                         ((birim_i == 3'd4) && yz_en_i);
    assign tek_cevrim  = (birim_i == 3'd0) || (birim_i == 3'd5) ||
                         ((birim_i == 3'd4) && !yz_en_i);
    assign kabul       = (durum == BOSTA) && gecerli_i && !bosalt_i;
    assign aktif_bitti = |(bitti_i & birim_maskesi(aktif_birim));

    // Stall must be visible in the accept cycle itself, hence combinational.
    assign durdur_o = rst_ni && ((durum == BEKLE) || (kabul && cok_cevrim));
    assign mesgul_o = (durum != BOSTA);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            durum           <= BOSTA;
            sayac           <= '0;
            aktif_birim     <= 3'd0;
            zaman_doldu     <= 1'b0;
            baslat_o        <= 4'b0000;
            iptal_o         <= 1'b0;
            sonuc_gecerli_o <= 1'b0;
            sonuc_birim_o   <= 3'd0;
            zaman_asimi_o   <= 1'b0;
        end else begin
            baslat_o        <= 4'b0000;
            iptal_o         <= 1'b0;
            sonuc_gecerli_o <= 1'b0;
            sonuc_birim_o   <= 3'd0;
            zaman_asimi_o   <= 1'b0;
            case (durum)
                BOSTA: begin
                    if (kabul) begin
                        if (cok_cevrim) begin
                            baslat_o    <= birim_maskesi(birim_i);
                            aktif_birim <= birim_i;
                            sayac       <= '0;
                            zaman_doldu <= 1'b0;
                            durum       <= BEKLE;
                        end else if (tek_cevrim) begin
                            sonuc_gecerli_o <= 1'b1;
                            sonuc_birim_o   <= birim_i;
                        end
                    end
                end
                BEKLE: begin
                    sayac <= sayac + SW'(1);
                    // Flush beats done, and done beats the watchdog.
                    if (bosalt_i) begin
                        iptal_o <= 1'b1;
                        durum   <= BOSTA;
                    end else if (aktif_bitti) begin
                        zaman_doldu <= 1'b0;
                        durum       <= TAMAM;
                    end else if (sayac == SON_SAYI) begin
                        zaman_doldu   <= 1'b1;
                        iptal_o       <= 1'b1;
                        zaman_asimi_o <= 1'b1;
                        durum         <= TAMAM;
                    end
                end
                TAMAM: begin
                    durum <= BOSTA;
                    if (bosalt_i) begin
                        iptal_o <= 1'b1;
                    end else if (!zaman_doldu) begin
                        sonuc_gecerli_o <= 1'b1;
                        sonuc_birim_o   <= aktif_birim;
                    end
                end
                default: durum <= BOSTA;
            endcase
        end
    end
endmodule

// File: tb/tb_yurut_birim_zamanlayici.sv
// Bench for the execute-stage unit sequencer: directed scenarios plus a
// randomized transaction stream checked against a per-operation timing model.
module tb_yurut_birim_zamanlayici;
    localparam int ZA = 8;

    logic       clk_i;
    logic       rst_ni;
    logic       gecerli_i;
    logic [2:0] birim_i;
    logic       yz_en_i;
    logic       bosalt_i;
    logic [3:0] bitti_i;
    logic [3:0] baslat_o;
    logic       iptal_o;
    logic       durdur_o;
    logic       mesgul_o;
    logic       sonuc_gecerli_o;
    logic [2:0] sonuc_birim_o;
    logic       zaman_asimi_o;

    int kontroller;
    int hatalar;

    wire [11:0] obs = {baslat_o, iptal_o, durdur_o, mesgul_o,
                       sonuc_gecerli_o, sonuc_birim_o, zaman_asimi_o};

    yurut_birim_zamanlayici #(.ZAMAN_ASIMI(ZA)) dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .gecerli_i       (gecerli_i),
        .birim_i         (birim_i),
        .yz_en_i         (yz_en_i),
        .bosalt_i        (bosalt_i),
        .bitti_i         (bitti_i),
        .baslat_o        (baslat_o),
        .iptal_o         (iptal_o),
        .durdur_o        (durdur_o),
        .mesgul_o        (mesgul_o),
        .sonuc_gecerli_o (sonuc_gecerli_o),
        .sonuc_birim_o   (sonuc_birim_o),
        .zaman_asimi_o   (zaman_asimi_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Packs expected outputs in the same order as obs.
    function automatic logic [11:0] pk(input logic [3:0] b, input logic ip, input logic du,
                                       input logic me, input logic sg, input logic [2:0] sb,
                                       input logic zt);
        return {b, ip, du, me, sg, sb, zt};
    endfunction

    task automatic saat();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0; gecerli_i = 1'b0; birim_i = 3'd0; yz_en_i = 1'b0;
        bosalt_i = 1'b0; bitti_i = 4'b0000;
        #2;
        kontroller++;
        if (obs !== 12'h000) begin $display("FAIL reset_init got=%h exp=%h", obs, 12'h000); hatalar++; end
        saat();
        rst_ni = 1'b1;
        #4;
        kontroller++;
        if (obs !== 12'h000) begin $display("FAIL reset_release got=%h exp=%h", obs, 12'h000); hatalar++; end
        saat();
        gecerli_i = 1'b1; birim_i = 3'd1;
        #4;
        kontroller++;
        if (obs !== pk(4'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0)) begin
            $display("FAIL reset_accept got=%h exp=%h", obs, pk(4'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0)); hatalar++;
        end
        saat();
        #4;
        kontroller++;
        if (obs !== pk(4'b0001, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0)) begin
            $display("FAIL reset_bekle got=%h exp=%h", obs, pk(4'b0001, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0)); hatalar++;
        end
        saat();
        saat();
        #2;
        rst_ni = 1'b0;
        #1;
        kontroller++;
        if (obs !== 12'h000) begin $display("FAIL reset_async got=%h exp=%h", obs, 12'h000); hatalar++; end
        gecerli_i = 1'b0;
        saat();
        rst_ni = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #4;
            kontroller++;
            if (obs !== 12'h000) begin $display("FAIL reset_no_abort c=%0d got=%h exp=%h", i, obs, 12'h000); hatalar++; end
            saat();
        end
    endtask

    task automatic test_single_stream();
        logic [2:0]  seq [6];
        logic        gq  [6];
        logic [11:0] ex  [6];
        seq = '{3'd0, 3'd5, 3'd0, 3'd6, 3'd7, 3'd0};
        gq  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        ex[0] = 12'h000;
        ex[1] = pk(4'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0);
        ex[2] = pk(4'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd5, 1'b0);
        ex[3] = pk(4'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0);
        ex[4] = 12'h000;
        ex[5] = 12'h000;
        for (int i = 0; i < 6; i++) begin
            gecerli_i = gq[i]; birim_i = seq[i];
            #4;
            kontroller++;
            if (obs !== ex[i]) begin $display("FAIL single_stream c=%0d got=%h exp=%h", i, obs, ex[i]); hatalar++; end
            saat();
        end
    endtask

    task automatic test_multi_normal();
        logic [11:0] e;
        for (int i = 0; i < 10; i++) begin
            gecerli_i = (i <= 7); birim_i = 3'd2;
            bitti_i = (i == 2) ? 4'b0001 : (i == 6) ? 4'b0010 : 4'b0000;
            if (i == 0)      e = pk(4'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0);
            else if (i <= 6) e = pk((i == 1) ? 4'b0010 : 4'b0000, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0);
            else if (i == 7) e = pk(4'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0);
            else if (i == 8) e = pk(4'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd2, 1'b0);
            else             e = 12'h000;
            #4;
            kontroller++;
            if (obs !== e) begin $display("FAIL multi_normal c=%0d got=%h exp=%h", i, obs, e); hatalar++; end
            saat();
        end
        bitti_i = 4'b0000; gecerli_i = 1'b0;
    endtask

    task automatic test_timeout();
        logic [11:0] e;
        for (int i = 0; i < 12; i++) begin
            gecerli_i = (i <= 9); birim_i = 3'd1;
            bitti_i = (i == 4) ? 4'b1110 : 4'b0000;
            if (i == 0)      e = pk(4'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0);
            else if (i <= 8) e = pk((i == 1) ? 4'b0001 : 4'b0000, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0);
            else if (i == 9) e = pk(4'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 1'b1);
            else             e = 12'h000;
            #4;
            kontroller++;
            if (obs !== e) begin $display("FAIL timeout c=%0d got=%h exp=%h", i, obs, e); hatalar++; end
            saat();
        end
        // done in the last watchdog cycle wins over the timeout
        for (int i = 0; i < 12; i++) begin
            gecerli_i = (i <= 9); birim_i = 3'd3;
            bitti_i = (i == 8) ? 4'b0100 : 4'b0000;
            if (i == 0)       e = pk(4'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0);
            else if (i <= 8)  e = pk((i == 1) ? 4'b0100 : 4'b0000, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0);
            else if (i == 9)  e = pk(4'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0);
            else if (i == 10) e = pk(4'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd3, 1'b0);
            else              e = 12'h000;
            #4;
            kontroller++;
            if (obs !== e) begin $display("FAIL timeout_edge c=%0d got=%h exp=%h", i, obs, e); hatalar++; end
            saat();
        end
        bitti_i = 4'b0000; gecerli_i = 1'b0;
    endtask

    task automatic test_flush();
        logic [11:0] e;
        // flush and done together in BEKLE
        for (int i = 0; i < 5; i++) begin
            gecerli_i = (i <= 2); birim_i = 3'd3; bosalt_i = (i == 2);
            bitti_i = (i == 2) ? 4'b0100 : 4'b0000;
            if (i == 0)      e = pk(4'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0);
            else if (i <= 2) e = pk((i == 1) ? 4'b0100 : 4'b0000, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0);
            else if (i == 3) e = pk(4'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
            else             e = 12'h000;
            #4;
            kontroller++;
            if (obs !== e) begin $display("FAIL flush_bekle c=%0d got=%h exp=%h", i, obs, e); hatalar++; end
            saat();
        end
        // flush during TAMAM suppresses the result
        for (int i = 0; i < 5; i++) begin
            gecerli_i = (i <= 2); birim_i = 3'd1; bosalt_i = (i == 2);
            bitti_i = (i == 1) ? 4'b0001 : 4'b0000;
            if (i == 0)      e = pk(4'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0);
            else if (i == 1) e = pk(4'b0001, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0);
            else if (i == 2) e = pk(4'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0);
            else if (i == 3) e = pk(4'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
            else             e = 12'h000;
            #4;
            kontroller++;
            if (obs !== e) begin $display("FAIL flush_tamam c=%0d got=%h exp=%h", i, obs, e); hatalar++; end
            saat();
        end
        // flush in BOSTA blocks acceptance
        for (int i = 0; i < 2; i++) begin
            gecerli_i = (i == 0); birim_i = 3'd2; bosalt_i = (i == 0); bitti_i = 4'b0000;
            #4;
            kontroller++;
            if (obs !== 12'h000) begin $display("FAIL flush_bosta c=%0d got=%h exp=%h", i, obs, 12'h000); hatalar++; end
            saat();
        end
        bosalt_i = 1'b0; gecerli_i = 1'b0;
    endtask

    task automatic test_ai_gating();
        logic [11:0] e;
        yz_en_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            gecerli_i = (i == 0); birim_i = 3'd4;
            e = (i == 1) ? pk(4'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd4, 1'b0) : 12'h000;
            #4;
            kontroller++;
            if (obs !== e) begin $display("FAIL ai_off c=%0d got=%h exp=%h", i, obs, e); hatalar++; end
            saat();
        end
        yz_en_i = 1'b1;
        for (int i = 0; i < 7; i++) begin
            gecerli_i = (i <= 4); birim_i = 3'd4;
            bitti_i = (i == 2) ? 4'b0111 : (i == 3) ? 4'b1000 : 4'b0000;
            if (i == 0)      e = pk(4'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0);
            else if (i <= 3) e = pk((i == 1) ? 4'b1000 : 4'b0000, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0);
            else if (i == 4) e = pk(4'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0);
            else if (i == 5) e = pk(4'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd4, 1'b0);
            else             e = 12'h000;
            #4;
            kontroller++;
            if (obs !== e) begin $display("FAIL ai_on c=%0d got=%h exp=%h", i, obs, e); hatalar++; end
            saat();
        end
        bitti_i = 4'b0000; gecerli_i = 1'b0; yz_en_i = 1'b0;
    endtask

    // Each operation is planned up front: done offset d and flush offset f are
    // counted in wait cycles after the start pulse; the expected per-cycle
    // outputs follow from the accept/start/wait/exit timing rules.
    task automatic test_random();
        int          kod, d, f, te, w, bosluk;
        logic        yz, cok, tek, to;
        logic [3:0]  maske;
        logic [11:0] ex [16];
        logic        gc [16];
        logic        bs [16];
        for (int t = 0; t < 200; t++) begin
            bosluk = $urandom_range(0, 2);
            for (int g = 0; g < bosluk; g++) begin
                gecerli_i = 1'b0; birim_i = 3'($urandom); bitti_i = 4'($urandom);
                bosalt_i = 1'($urandom); yz_en_i = 1'($urandom);
                #4;
                kontroller++;
                if (obs !== 12'h000) begin $display("FAIL rnd_gap t=%0d got=%h exp=%h", t, obs, 12'h000); hatalar++; end
                saat();
            end
            kod = $urandom_range(0, 7);
            yz  = 1'($urandom);
            cok = (kod >= 1 && kod <= 3) || (kod == 4 && yz);
            tek = (kod == 0) || (kod == 5) || (kod == 4 && !yz);
            maske = cok ? 4'(1 << (kod - 1)) : 4'b0000;
            for (int i = 0; i < 16; i++) begin ex[i] = 12'h000; gc[i] = 1'b0; bs[i] = 1'b0; end
            d = 99; f = 99; gc[0] = 1'b1;
            if (!cok) begin
                w = 2;
                ex[1] = pk(4'b0, 1'b0, 1'b0, 1'b0, tek, tek ? 3'(kod) : 3'd0, 1'b0);
            end else begin
                d  = $urandom_range(0, 9);
                f  = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 9) : 99;
                te = (d < ZA) ? d : ZA - 1;
                to = (d >= ZA);
                ex[0] = pk(4'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0);
                if (f <= te) begin
                    for (int i = 1; i <= 1 + f; i++) begin
                        ex[i] = pk((i == 1) ? maske : 4'b0000, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0);
                        gc[i] = 1'b1;
                    end
                    bs[1 + f] = 1'b1;
                    ex[2 + f] = pk(4'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
                    w = 3 + f;
                end else begin
                    for (int i = 1; i <= 1 + te; i++) begin
                        ex[i] = pk((i == 1) ? maske : 4'b0000, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0);
                        gc[i] = 1'b1;
                    end
                    gc[2 + te] = 1'b1;
                    ex[2 + te] = pk(4'b0, to, 1'b0, 1'b1, 1'b0, 3'd0, to);
                    if (f == te + 1) begin
                        bs[2 + te] = 1'b1;
                        ex[3 + te] = pk(4'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
                    end else begin
                        ex[3 + te] = pk(4'b0, 1'b0, 1'b0, 1'b0, !to, to ? 3'd0 : 3'(kod), 1'b0);
                    end
                    w = 4 + te;
                end
            end
            for (int i = 0; i < w; i++) begin
                gecerli_i = gc[i];
                birim_i   = gc[i] ? 3'(kod) : 3'($urandom);
                yz_en_i   = yz;
                bosalt_i  = bs[i];
                bitti_i   = (4'($urandom) & ~maske) | ((i == 1 + d) ? maske : 4'b0000);
                #4;
                kontroller++;
                if (obs !== ex[i]) begin
                    $display("FAIL rnd t=%0d kod=%0d yz=%0d d=%0d f=%0d c=%0d got=%h exp=%h",
                             t, kod, yz, d, f, i, obs, ex[i]);
                    hatalar++;
                end
                saat();
            end
        end
        gecerli_i = 1'b0; bosalt_i = 1'b0; bitti_i = 4'b0000;
    endtask

    initial begin
        kontroller = 0;
        hatalar    = 0;
        test_reset();
        test_single_stream();
        test_multi_normal();
        test_timeout();
        test_flush();
        test_ai_gating();
        test_random();
        $display("CHECKS %0d ERRORS %0d", kontroller, hatalar);
        $finish;
    end
endmodule
